// File: rtl/lutram_dp_clr_if.sv
// Port bundle for lutram_dp_clr: port A read/write, port B read, clear request and status.
interface lutram_dp_clr_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 5
);
    logic              CLR;
    logic              WE;
    logic [ADDR_W-1:0] A;
    logic [ADDR_W-1:0] DPRA;
    logic [DATA_W-1:0] D;
    logic              BUSY;
    logic [DATA_W-1:0] SPO;
    logic [DATA_W-1:0] DPO;

    modport master (output CLR, WE, A, DPRA, D, input BUSY, SPO, DPO);
    modport slave  (input CLR, WE, A, DPRA, D, output BUSY, SPO, DPO);
endinterface

// File: rtl/lutram_dp_clr.sv
// Dual-port distributed RAM with a clear sweep after reset or on request and an
// optional registered read stage.
module lutram_dp_clr #(
    parameter int unsigned       DATA_W  = 8,
    parameter int unsigned       ADDR_W  = 5,
    parameter int unsigned       OUT_REG = 0,
    parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
    input logic            CLK,
    input logic            RST,
    lutram_dp_clr_if.slave bus
);
    localparam int unsigned       DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_addr;
    logic              busy;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;

    // Sweep sequencer: CLR is only honoured from IDLE, so a running sweep never restarts.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    clr_addr <= clr_addr + ADDR_W'(1);
                    if (clr_addr == LAST_ADDR) state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (bus.CLR) begin
                        state    <= ST_CLEAR;
                        clr_addr <= '0;
                    end
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

    assign busy     = (state == ST_CLEAR);
    assign bus.BUSY = busy;

    // Single write port shared between the sweep and user writes; the sweep always wins.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = bus.A;
        mem_wdata = bus.D;
        if (!RST) begin
            if (busy) begin
                mem_we    = 1'b1;
                mem_waddr = clr_addr;
                mem_wdata = CLR_VAL;
            end else if (bus.WE && !bus.CLR) begin
                mem_we = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    assign rd_a = busy ? CLR_VAL : mem[bus.A];
    assign rd_b = busy ? CLR_VAL : mem[bus.DPRA];

    generate
        if (OUT_REG != 0) begin : g_out_reg
            // Registered reads sample the array before this edge's write lands.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    bus.SPO <= CLR_VAL;
                    bus.DPO <= CLR_VAL;
                end else begin
                    bus.SPO <= rd_a;
                    bus.DPO <= rd_b;
                end
            end
        end else begin : g_out_comb
            assign bus.SPO = rd_a;
            assign bus.DPO = rd_b;
        end
    endgenerate
endmodule

// File: tb/tb_lutram_dp_clr.sv
// Directed bench: one asynchronous-read and one registered-read instance driven in lockstep.
module tb_lutram_dp_clr;
    localparam logic [7:0] CV = 8'hA5;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr, we;
    logic [3:0] a, dpra;
    logic [7:0] d;
    int         total = 0;
    int         bad   = 0;

    lutram_dp_clr_if #(.DATA_W(8), .ADDR_W(4)) if0 ();
    lutram_dp_clr_if #(.DATA_W(8), .ADDR_W(4)) if1 ();

    assign if0.CLR = clr;  assign if1.CLR = clr;
    assign if0.WE = we;    assign if1.WE = we;
    assign if0.A = a;      assign if1.A = a;
    assign if0.DPRA = dpra; assign if1.DPRA = dpra;
    assign if0.D = d;      assign if1.D = d;

    lutram_dp_clr #(.DATA_W(8), .ADDR_W(4), .OUT_REG(0), .CLR_VAL(CV)) dut0 (
        .CLK(clk), .RST(rst), .bus(if0.slave));
    lutram_dp_clr #(.DATA_W(8), .ADDR_W(4), .OUT_REG(1), .CLR_VAL(CV)) dut1 (
        .CLK(clk), .RST(rst), .bus(if1.slave));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        total++; if (if0.BUSY !== 1'b1) begin bad++; $display("FAIL reset_busy0 got=%b exp=1", if0.BUSY); end
        total++; if (if1.BUSY !== 1'b1) begin bad++; $display("FAIL reset_busy1 got=%b exp=1", if1.BUSY); end
        total++; if (if1.SPO !== CV || if1.DPO !== CV) begin bad++; $display("FAIL reset_out1 spo=%h dpo=%h exp=%h", if1.SPO, if1.DPO, CV); end
        rst = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            step();
            total++; if (if0.BUSY !== (i < 16)) begin bad++; $display("FAIL sweep_busy edge=%0d got=%b exp=%b", i, if0.BUSY, (i < 16)); end
            total++; if (if0.SPO !== CV || if1.SPO !== CV || if1.DPO !== CV) begin
                bad++; $display("FAIL sweep_mask edge=%0d spo0=%h spo1=%h dpo1=%h exp=%h", i, if0.SPO, if1.SPO, if1.DPO, CV); end
        end
        for (int i = 0; i < 16; i++) begin
            a = 4'(i); dpra = 4'(15 - i);
            #1;
            total++; if (if0.SPO !== CV || if0.DPO !== CV) begin bad++; $display("FAIL swept_content addr=%0d spo=%h dpo=%h exp=%h", i, if0.SPO, if0.DPO, CV); end
        end
        step();
        total++; if (if1.SPO !== CV || if1.BUSY !== 1'b0) begin bad++; $display("FAIL first_reg_read spo=%h busy=%b exp=%h/0", if1.SPO, if1.BUSY, CV); end
    endtask

    task automatic test_write_read();
        a = 4'd7; d = 8'h3C; we = 1'b1;
        step();
        we = 1'b0;
        total++; if (if0.SPO !== 8'h3C) begin bad++; $display("FAIL wr_spo got=%h exp=3c", if0.SPO); end
        dpra = 4'd7; #1;
        total++; if (if0.DPO !== 8'h3C) begin bad++; $display("FAIL wr_dpo7 got=%h exp=3c", if0.DPO); end
        dpra = 4'd6; #1;
        total++; if (if0.DPO !== CV) begin bad++; $display("FAIL wr_dpo6 got=%h exp=%h", if0.DPO, CV); end
    endtask

    task automatic test_read_first();
        a = 4'd2; d = 8'h11; we = 1'b1;
        step();
        d = 8'h22;
        step();
        we = 1'b0;
        total++; if (if1.SPO !== 8'h11) begin bad++; $display("FAIL read_first_old got=%h exp=11", if1.SPO); end
        total++; if (if0.SPO !== 8'h22) begin bad++; $display("FAIL async_new got=%h exp=22", if0.SPO); end
        step();
        total++; if (if1.SPO !== 8'h22) begin bad++; $display("FAIL read_first_new got=%h exp=22", if1.SPO); end
    endtask

    task automatic test_clr_with_we();
        clr = 1'b1; we = 1'b1; a = 4'd3; d = 8'hFF;
        step();
        clr = 1'b0;
        total++; if (if0.BUSY !== 1'b1 || if0.SPO !== CV) begin bad++; $display("FAIL clr_start busy=%b spo=%h exp=1/%h", if0.BUSY, if0.SPO, CV); end
        for (int i = 1; i <= 16; i++) begin
            step();
            total++; if (if0.BUSY !== (i < 16)) begin bad++; $display("FAIL clr_busy edge=%0d got=%b exp=%b", i, if0.BUSY, (i < 16)); end
        end
        we = 1'b0; dpra = 4'd7; #1;
        total++; if (if0.SPO !== CV) begin bad++; $display("FAIL clr_dropped_write got=%h exp=%h", if0.SPO, CV); end
        total++; if (if0.DPO !== CV) begin bad++; $display("FAIL clr_swept_7 got=%h exp=%h", if0.DPO, CV); end
    endtask

    task automatic test_rst_mid_sweep();
        clr = 1'b1;
        step();
        clr = 1'b0;
        for (int i = 1; i <= 8; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if (if0.BUSY !== 1'b1) begin bad++; $display("FAIL rst_mid_busy got=%b exp=1", if0.BUSY); end
        for (int i = 1; i <= 16; i++) begin
            step();
            total++; if (if0.BUSY !== (i < 16)) begin bad++; $display("FAIL rst_mid_sweep edge=%0d got=%b exp=%b", i, if0.BUSY, (i < 16)); end
        end
    endtask

    task automatic test_clr_during_clear();
        clr = 1'b1;
        step();
        clr = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            clr = (i == 5);
            step();
            total++; if (if0.BUSY !== (i < 16)) begin bad++; $display("FAIL clr_in_clear edge=%0d got=%b exp=%b", i, if0.BUSY, (i < 16)); end
        end
        clr = 1'b0;
        step();
        total++; if (if0.BUSY !== 1'b0) begin bad++; $display("FAIL clr_in_clear_idle got=%b exp=0", if0.BUSY); end
    endtask

    task automatic test_back_to_back();
        we = 1'b1;
        a = 4'd15; d = 8'hF0; step();
        a = 4'd0;  d = 8'h0F; step();
        a = 4'd9;  d = 8'h5A; step();
        we = 1'b0; dpra = 4'd9; #1;
        total++; if (if0.SPO !== 8'h5A || if0.DPO !== 8'h5A) begin bad++; $display("FAIL same_addr spo=%h dpo=%h exp=5a", if0.SPO, if0.DPO); end
        a = 4'd15; dpra = 4'd0; #1;
        total++; if (if0.SPO !== 8'hF0 || if0.DPO !== 8'h0F) begin bad++; $display("FAIL edge_addrs spo=%h dpo=%h exp=f0/0f", if0.SPO, if0.DPO); end
        step();
        total++; if (if1.SPO !== 8'hF0 || if1.DPO !== 8'h0F) begin bad++; $display("FAIL edge_addrs_reg spo=%h dpo=%h exp=f0/0f", if1.SPO, if1.DPO); end
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; we = 1'b0; a = '0; dpra = '0; d = '0;
        test_reset();
        test_write_read();
        test_read_first();
        test_clr_with_we();
        test_rst_mid_sweep();
        test_clr_during_clear();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
